// File: rtl/mont_pkg.sv
// Shared types and sizing for the Montgomery exponentiation sequencer.
package mont_pkg;

  localparam int W  = 128;
  localparam int EW = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } state_t;

  typedef enum logic {
    OP_SQR,
    OP_MUL
  } op_kind_t;

endpackage

// File: rtl/mont_exp_if.sv
// Start/address/done handshake between the sequencer and the multiplier.
interface mont_exp_if #(
  parameter int W = 128
);

  logic          mm_start;
  logic [31:0]   mm_A_addr;
  logic [31:0]   mm_B_addr;
  logic [31:0]   mm_N_addr;
  logic [31:0]   mm_res_addr;
  logic          mm_done;
  logic [W-1:0]  mm_result;

  // Sequencer side
  modport master (
    output mm_start, mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr,
    input  mm_done, mm_result
  );

  // Multiplier side
  modport slave (
    input  mm_start, mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr,
    output mm_done, mm_result
  );

endinterface

// File: rtl/lzc_msb.sv
// Priority encoder: index of the most significant set bit plus an all-zero flag.
module lzc_msb #(
  parameter int EW = 128
) (
  input  logic [EW-1:0]         vec,
  output logic [$clog2(EW)-1:0] msb_idx,
  output logic                  zero
);

  localparam int KW = $clog2(EW);

  // Later (higher) set bits overwrite earlier ones, leaving the MSB index.
  always_comb begin
    msb_idx = '0;
    zero    = ~|vec;
    for (int i = 0; i < EW; i++) begin
      if (vec[i]) msb_idx = KW'(i);
    end
  end

endmodule

// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply sequencer driving mont_mul. Chooses
// operand/result addresses only; the multiplier does all memory traffic.
module mont_exp
  import mont_pkg::*;
#(
  parameter int W  = mont_pkg::W,
  parameter int EW = mont_pkg::EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [EW-1:0] exp,
  input  logic [31:0]   base_addr,
  input  logic [31:0]   one_addr,
  input  logic [31:0]   N_addr,
  input  logic [31:0]   scratch_addr,
  input  logic [31:0]   res_addr,
  mont_exp_if.master    mm,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [8:0]    op_count
);

  localparam int KW   = $clog2(EW);
  localparam int SLOT = W / 8;

  state_t        state_reg, state_next;
  op_kind_t      op_reg, op_next;
  logic [EW-1:0] exp_reg, exp_next;
  logic [KW-1:0] idx_reg, idx_next;
  logic          last_reg, last_next;
  logic          acc_t0_reg, acc_t0_next;  // acc lives in T0 (else T1)
  logic [31:0]   base_reg, base_next;
  logic [31:0]   n_reg, n_next;
  logic [31:0]   t0_reg, t0_next;
  logic [31:0]   t1_reg, t1_next;
  logic [31:0]   res_reg, res_next;
  logic          mm_start_reg, mm_start_next;
  logic [31:0]   a_reg, a_next;
  logic [31:0]   b_reg, b_next;
  logic [31:0]   r_reg, r_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [W-1:0]  result_reg, result_next;
  logic [8:0]    cnt_reg, cnt_next;

  logic [KW-1:0] lz_idx;
  logic          lz_zero;

  lzc_msb #(.EW(EW)) u_lzc (
    .vec     (exp),
    .msb_idx (lz_idx),
    .zero    (lz_zero)
  );

  // First op is last when the exponent is zero (Mont(R,R)) or has only bit 0 set.
  logic first_last;
  assign first_last = lz_zero | (lz_idx == '0);

  // Candidate follow-on op, derived from the op that just completed.
  logic          take_mul;
  op_kind_t      nop;
  logic [KW-1:0] nidx;
  logic          nlast;
  logic [31:0]   acc_addr;
  logic [31:0]   ndest;

  assign take_mul = (op_reg == OP_SQR) && exp_reg[idx_reg];
  assign nop      = take_mul ? OP_MUL : OP_SQR;
  assign nidx     = take_mul ? idx_reg : idx_reg - 1'b1;
  assign nlast    = (nidx == '0) && ((nop == OP_MUL) || !exp_reg[0]);
  assign acc_addr = acc_t0_reg ? t0_reg : t1_reg;
  assign ndest    = nlast ? res_reg : (acc_t0_reg ? t1_reg : t0_reg);

  // Next-state and registered-output logic.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    exp_next      = exp_reg;
    idx_next      = idx_reg;
    last_next     = last_reg;
    acc_t0_next   = acc_t0_reg;
    base_next     = base_reg;
    n_next        = n_reg;
    t0_next       = t0_reg;
    t1_next       = t1_reg;
    res_next      = res_reg;
    mm_start_next = 1'b0;
    a_next        = a_reg;
    b_next        = b_reg;
    r_next        = r_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    result_next   = result_reg;
    cnt_next      = cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          exp_next      = exp;
          base_next     = base_addr;
          n_next        = N_addr;
          t0_next       = scratch_addr;
          t1_next       = scratch_addr + 32'(SLOT);
          res_next      = res_addr;
          op_next       = OP_MUL;
          idx_next      = lz_idx;
          last_next     = first_last;
          acc_t0_next   = 1'b1;
          a_next        = one_addr;
          b_next        = lz_zero ? one_addr : base_addr;
          r_next        = first_last ? res_addr : scratch_addr;
          mm_start_next = 1'b1;
          busy_next     = 1'b1;
          cnt_next      = 9'd1;
          state_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mm.mm_done) begin
          if (last_reg) begin
            result_next = mm.mm_result;
            done_next   = 1'b1;
            busy_next   = 1'b0;
            state_next  = ST_FIN;
          end else begin
            op_next       = nop;
            idx_next      = nidx;
            last_next     = nlast;
            acc_t0_next   = !acc_t0_reg;
            a_next        = acc_addr;
            b_next        = (nop == OP_MUL) ? base_reg : acc_addr;
            r_next        = ndest;
            mm_start_next = 1'b1;
            cnt_next      = cnt_reg + 9'd1;
            state_next    = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_SQR;
      exp_reg      <= '0;
      idx_reg      <= '0;
      last_reg     <= 1'b0;
      acc_t0_reg   <= 1'b0;
      base_reg     <= '0;
      n_reg        <= '0;
      t0_reg       <= '0;
      t1_reg       <= '0;
      res_reg      <= '0;
      mm_start_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      r_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      exp_reg      <= exp_next;
      idx_reg      <= idx_next;
      last_reg     <= last_next;
      acc_t0_reg   <= acc_t0_next;
      base_reg     <= base_next;
      n_reg        <= n_next;
      t0_reg       <= t0_next;
      t1_reg       <= t1_next;
      res_reg      <= res_next;
      mm_start_reg <= mm_start_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      r_reg        <= r_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign mm.mm_start    = mm_start_reg;
  assign mm.mm_A_addr   = a_reg;
  assign mm.mm_B_addr   = b_reg;
  assign mm.mm_N_addr   = n_reg;
  assign mm.mm_res_addr = r_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign result         = result_reg;
  assign op_count       = cnt_reg;

endmodule

// File: tb/tb_mont_exp.sv
// Bench for mont_exp with a fixed-latency mock multiplier and an op scoreboard.
module tb_mont_exp;

  localparam int W  = 128;
  localparam int EW = 128;
  localparam int L  = 5;

  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] ONE  = 32'h110;
  localparam logic [31:0] NAD  = 32'h120;
  localparam logic [31:0] T0   = 32'h200;
  localparam logic [31:0] T1   = 32'h210;
  localparam logic [31:0] RES  = 32'h300;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [EW-1:0] exp_in;
  logic          busy, done;
  logic [W-1:0]  result;
  logic [8:0]    op_count;

  int tests = 0;
  int fails = 0;
  op_t q[$];

  mont_exp_if #(.W(W)) mif ();

  mont_exp #(.W(W), .EW(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .exp          (exp_in),
    .base_addr    (BASE),
    .one_addr     (ONE),
    .N_addr       (NAD),
    .scratch_addr (T0),
    .res_addr     (RES),
    .mm           (mif),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  // Mock multiplier: done L cycles after start, result tagged by addresses.
  logic [L-1:0] sr;
  always @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[L-2:0], mif.mm_start};
  end
  assign mif.mm_done   = sr[L-1];
  assign mif.mm_result = {~mif.mm_A_addr, mif.mm_A_addr ^ mif.mm_B_addr,
                          mif.mm_B_addr, mif.mm_res_addr};

  function automatic logic [W-1:0] mock_val(input op_t o);
    return {~o.a, o.a ^ o.b, o.b, o.r};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference op list: MSB-first bit walk, then a pass assigning addresses.
  task automatic build(input logic [EW-1:0] e);
    bit   kinds[$];   // 1 = MUL, 0 = SQR
    int   k;
    logic [31:0] prev;
    bit   use_t1;
    op_t  o;
    q.delete();
    if (e == '0) begin
      o.a = ONE; o.b = ONE; o.r = RES;
      q.push_back(o);
      return;
    end
    k = -1;
    for (int i = EW - 1; i >= 0; i--) if (e[i] && k < 0) k = i;
    kinds.push_back(1'b1);
    for (int i = k - 1; i >= 0; i--) begin
      kinds.push_back(1'b0);
      if (e[i]) kinds.push_back(1'b1);
    end
    prev   = ONE;
    use_t1 = 1'b0;
    for (int j = 0; j < kinds.size(); j++) begin
      o.a = prev;
      o.b = kinds[j] ? BASE : prev;
      if (j == kinds.size() - 1) o.r = RES;
      else begin
        o.r    = use_t1 ? T1 : T0;
        use_t1 = !use_t1;
      end
      prev = o.r;
      q.push_back(o);
    end
  endtask

  task automatic run_exp(input string name, input logic [EW-1:0] e, input bit poke);
    int  ops;
    op_t cur, last_op;
    bit  got_done;
    build(e);
    ops      = q.size();
    last_op  = q[ops-1];
    cur      = '0;
    got_done = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    exp_in = e;
    @(negedge clk);
    start  = 1'b0;
    for (int j = 1; j <= 4000 && !got_done; j++) begin
      if (j > 1) @(negedge clk);
      if (poke && j == 3) begin start = 1'b1; exp_in = '0; end
      if (poke && j == 4) start = 1'b0;
      if (j == 1) check($sformatf("%s busy", name), 128'(busy), 128'(1));
      if (mif.mm_start) begin
        if (q.size() == 0) check($sformatf("%s extra op", name), 128'(1), 128'(0));
        else begin
          cur = q.pop_front();
          check($sformatf("%s op addr", name),
                {mif.mm_A_addr, mif.mm_B_addr, mif.mm_res_addr, mif.mm_N_addr},
                {cur.a, cur.b, cur.r, NAD});
        end
      end
      if (mif.mm_done)
        check($sformatf("%s addr hold", name),
              {32'h0, mif.mm_A_addr, mif.mm_B_addr, mif.mm_res_addr}, {32'h0, cur});
      if (done) begin
        got_done = 1'b1;
        check($sformatf("%s latency", name), 128'(j), 128'(ops * (L + 1) + 1));
        check($sformatf("%s result", name), result, mock_val(last_op));
        check($sformatf("%s op_count", name), 128'(op_count), 128'(ops));
        check($sformatf("%s busy at done", name), 128'(busy), 128'(0));
        check($sformatf("%s ops left", name), 128'(q.size()), 128'(0));
      end
    end
    if (!got_done) check($sformatf("%s timeout", name), 128'(0), 128'(1));
    @(negedge clk);
    check($sformatf("%s post done/busy", name), {126'h0, done, busy}, 128'h0);
    $display("[TB] run %s exp=%0h ops=%0d result=%0h", name, e, ops, result);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    exp_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ctl", {124'h0, busy, done, mif.mm_start, 1'b0}, 128'h0);
    check("reset addr", {mif.mm_A_addr, mif.mm_B_addr, mif.mm_N_addr, mif.mm_res_addr}, 128'h0);
    check("reset result", result, 128'h0);
    check("reset op_count", 128'(op_count), 128'h0);

    run_exp("exp0", 128'h0, 1'b0);
    run_exp("exp1", 128'h1, 1'b0);
    run_exp("expB", 128'hB, 1'b0);
    run_exp("exp2p127", 128'h1 << 127, 1'b0);
    run_exp("allones", {128{1'b1}}, 1'b0);
    run_exp("rand16", 128'($urandom_range(2, 65535)), 1'b0);
    run_exp("start_in_wait", 128'hB, 1'b1);

    // Reset during WAIT aborts the run.
    @(negedge clk);
    start  = 1'b1;
    exp_in = 128'hB;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy/start/done", {125'h0, busy, mif.mm_start, done}, 128'h0);
    check("rst op_count/addr", {87'h0, op_count, mif.mm_A_addr}, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    run_exp("after_rst", 128'h5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
